decimator: RTL and testbench
============================

DECIMATOR -- requirements
Module: decimator

Interface
REQ-001 The block SHALL take parameter RATIO_LOG2, default 2, meaning log2 of the decimation ratio N (legal 1..4).
REQ-002 The block SHALL take parameter FIFO_DEPTH, default 4, meaning output FIFO entries (power of two, 2..16).
REQ-003 Port CLK  input  1  sole clock; all state updates on posedge CLK.
REQ-004 Port RST  input  1  synchronous, active-high reset, sampled on posedge CLK.
REQ-005 Port in_data  input  8  filtered sample from the upstream 3-tap smoothing filter.
REQ-006 Port in_valid  input  1  in_data valid this cycle; no backpressure to upstream.
REQ-007 Port out_data  output  8  decimated sample at FIFO head.
REQ-008 Port out_valid  output  1  FIFO non-empty.
REQ-009 Port out_ready  input  1  consumer accepts out_data this cycle.
REQ-010 Port overflow  output  1  sticky: a decimated result was dropped.
REQ-011 Port level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-012 A sample SHALL be accepted on every posedge where in_valid=1 and RST=0.
REQ-013 Accumulator width SHALL be 8+RATIO_LOG2 bits; no sample combination SHALL overflow it.
REQ-014 Phase counter SHALL count accepted samples 0..N-1 and wrap to 0 after the Nth.
REQ-015 On the Nth accepted sample, the result SHALL be (acc + in_data) >> RATIO_LOG2, truncated (floor), with the accumulator cleared to 0 in the same edge.
REQ-016 On samples 1..N-1, acc SHALL become acc + in_data.
REQ-017 The result SHALL be pushed into the FIFO on the same edge that the Nth sample is accepted; out_valid SHALL go high the following cycle if the FIFO was empty (1-cycle latency from Nth sample edge).
REQ-018 in_valid=0 cycles SHALL hold acc and phase unchanged (gaps do not break a window).
REQ-019 A pop SHALL occur on a posedge where out_valid=1 and out_ready=1; out_data SHALL advance to the next entry or out_valid drop.
REQ-020 out_ready with out_valid=0 SHALL have no effect.
REQ-021 out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-022 FIFO order SHALL be strict first-in first-out; read/write pointers wrap modulo FIFO_DEPTH.
REQ-023 Push and pop on the same edge SHALL both occur, level unchanged, including when full or when level=1.
REQ-024 Push when full without a simultaneous pop SHALL drop the new result, leave FIFO contents and level unchanged, and set overflow=1.
REQ-025 overflow SHALL remain 1 until reset; further results SHALL continue normally once space exists.
REQ-026 level SHALL equal pushes minus pops since reset, range 0..FIFO_DEPTH.

Reset
REQ-027 With RST=1 at a posedge: acc=0, phase=0, FIFO empty, level=0, out_valid=0, overflow=0, out_data=0.
REQ-028 RST SHALL take priority over in_valid and out_ready on the same edge; a partial window in progress SHALL be discarded.
REQ-029 Outputs SHALL reflect reset values from the cycle after the reset edge; first accepted sample after deassertion SHALL be phase 0.

Verification
REQ-030 N=4, out_ready=1, in_valid=1, samples 10,20,30,41 -> one output 25 (101>>2), out_valid high exactly one cycle after the 41 edge.
REQ-031 Samples 255 x4 -> output 255, no wrap; samples 1,1,1,0 -> output 0 (floor).
REQ-032 in_valid pattern 1,0,0,1,1,0,1 with samples 4,x,x,8,12,x,16 -> single output 10 after the 16.
REQ-033 out_ready=0, 20 samples of 8 (5 results) -> level=4, out_valid=1, overflow=1, out_data=8 held; then out_ready=1 drains exactly 4 entries of 8.
REQ-034 Full FIFO with out_ready=1 on the edge a new result arrives -> level stays 4, overflow stays 0, FIFO order preserved.
REQ-035 RST pulsed after 2 of 4 samples -> no output from that window; next 4 samples 4,4,4,4 -> output 4, overflow=0.

Source files
------------

// File: rtl/decimator_if.sv
// decimator_if: sample-in / decimated-out bundle for the decimator.
//   in_data/in_valid   : filtered samples from upstream; no backpressure
//   out_data/out_valid : head of the output FIFO; out_ready pops it
//   overflow           : sticky, a decimated result was dropped
//   level              : current FIFO occupancy (0..FIFO_DEPTH)
// slave is the decimator side; master is the producer/consumer side.
interface decimator_if #(
   parameter int FIFO_DEPTH = 4
);
   logic [7:0]                    in_data;
   logic                          in_valid;
   logic [7:0]                    out_data;
   logic                          out_valid;
   logic                          out_ready;
   logic                          overflow;
   logic [$clog2(FIFO_DEPTH):0]   level;

   modport slave (
      input  in_data, in_valid, out_ready,
      output out_data, out_valid, overflow, level
   );

   modport master (
      output in_data, in_valid, out_ready,
      input  out_data, out_valid, overflow, level
   );
endinterface

// File: rtl/decimator.sv
// decimator: averages every N = 2**RATIO_LOG2 accepted samples into one
// output sample (floor of the mean) and queues results in a small FIFO.
//   CLK      : sole clock, all state on posedge
//   RST      : synchronous active-high reset
//   bus      : decimator_if.slave (samples in, decimated samples out,
//              overflow flag, FIFO level)
// Parameters: RATIO_LOG2 (1..4), FIFO_DEPTH (power of two, 2..16).
module decimator #(
   parameter int RATIO_LOG2 = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       CLK,
   input  logic       RST,
   decimator_if.slave bus
);
   localparam int AW = 8 + RATIO_LOG2;          // N*255 always fits
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = PW + 1;

   logic [AW-1:0]         acc;
   logic [RATIO_LOG2-1:0] phase;
   logic [AW-1:0]         sum;
   logic [7:0]            result;
   logic                  last;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [LW-1:0] level_q;
   logic          overflow_q;
   logic          full, out_valid, pop, push, do_push, drop;

   // ---------------- accumulate / decimate ----------------
   assign sum    = acc + {{RATIO_LOG2{1'b0}}, bus.in_data};
   assign result = sum[AW-1:RATIO_LOG2];        // floor(sum / N)
   assign last   = &phase;                      // phase == N-1

   // ---------------- FIFO control ----------------
   assign out_valid = (level_q != '0);
   assign full      = (level_q == LW'(FIFO_DEPTH));
   assign pop       = out_valid & bus.out_ready;
   assign push      = bus.in_valid & last;
   // A full FIFO still takes the new result if the head leaves on the same
   // edge; the write slot then coincides with the slot being vacated.
   assign do_push   = push & (~full | pop);
   assign drop      = push & full & ~pop;

   always_ff @(posedge CLK) begin
      if (RST) begin
         acc        <= '0;
         phase      <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (bus.in_valid) begin
            if (last) begin
               acc   <= '0;
               phase <= '0;
            end else begin
               acc   <= sum;
               phase <= phase + 1'b1;
            end
         end
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         if (drop)    overflow_q <= 1'b1;
         case ({do_push, pop})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

   // Storage needs no reset: it is only visible while level is non-zero.
   always_ff @(posedge CLK) begin
      if (!RST && do_push) mem[wr_ptr] <= result;
   end

   assign bus.out_valid = out_valid;
   assign bus.out_data  = out_valid ? mem[rd_ptr] : 8'd0;
   assign bus.overflow  = overflow_q;
   assign bus.level     = level_q;
endmodule

// File: tb/tb_decimator.sv
// tb_decimator: directed cases with literal expectations plus randomized
// traffic, all checked every cycle against a queue-based mean/FIFO model.
module tb_decimator;
   localparam int R     = 2;
   localparam int N     = 1 << R;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   decimator_if #(.FIFO_DEPTH(DEPTH)) bus ();

   decimator #(.RATIO_LOG2(R), .FIFO_DEPTH(DEPTH)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [7:0] q[$];
   int         wsum = 0;
   int         wcnt = 0;
   logic       m_ovf = 1'b0;
   bit         started = 1'b0;

   task automatic model_step();
      bit do_pop, was_full, got;
      int res;
      if (rst) begin
         q.delete();
         wsum = 0; wcnt = 0; m_ovf = 1'b0;
      end else begin
         do_pop   = (q.size() != 0) && bus.out_ready;
         was_full = (q.size() == DEPTH);
         got = 1'b0; res = 0;
         if (bus.in_valid) begin
            wsum += int'(bus.in_data);
            wcnt++;
            if (wcnt == N) begin
               res = wsum / N; got = 1'b1; wsum = 0; wcnt = 0;
            end
         end
         if (do_pop) void'(q.pop_front());
         if (got) begin
            if (was_full && !do_pop) m_ovf = 1'b1;
            else q.push_back(8'(res));
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
      started = 1'b1;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Single compare process: every cycle, outputs vs model.
   initial forever begin
      @(negedge clk);
      if (started) begin
         chk("model_out_valid", int'(bus.out_valid), int'(q.size() != 0));
         chk("model_level", int'(bus.level), q.size());
         chk("model_overflow", int'(bus.overflow), int'(m_ovf));
         chk("model_out_data", int'(bus.out_data), (q.size() != 0) ? int'(q[0]) : 0);
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input logic r, input logic v, input logic [7:0] d, input logic rdy);
      rst           = r;
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.out_ready = rdy;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'($urandom), 1'b1);
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.in_data = 8'd0; bus.out_ready = 1'b0;

      // Reset state
      step(1, 1, 8'd99, 1);
      step(1, 1, 8'd99, 1);
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_level", int'(bus.level), 0);
      chk("rst_overflow", int'(bus.overflow), 0);
      chk("rst_out_data", int'(bus.out_data), 0);

      // 10,20,30,41 -> 25, valid exactly after the 41 edge
      step(0, 1, 8'd10, 1);
      step(0, 1, 8'd20, 1);
      step(0, 1, 8'd30, 1);
      chk("mean_not_early", int'(bus.out_valid), 0);
      step(0, 1, 8'd41, 1);
      chk("mean_valid", int'(bus.out_valid), 1);
      chk("mean_value", int'(bus.out_data), 25);
      idle(1);
      chk("mean_popped", int'(bus.out_valid), 0);

      // 255 x4 -> 255; 1,1,1,0 -> 0
      for (int i = 0; i < 4; i++) step(0, 1, 8'd255, 1);
      chk("max_value", int'(bus.out_data), 255);
      idle(1);
      step(0, 1, 8'd1, 1); step(0, 1, 8'd1, 1); step(0, 1, 8'd1, 1); step(0, 1, 8'd0, 1);
      chk("floor_valid", int'(bus.out_valid), 1);
      chk("floor_value", int'(bus.out_data), 0);
      idle(1);

      // Gaps keep the window: 4,-,-,8,12,-,16 -> 10
      step(0, 1, 8'd4, 1);  step(0, 0, 8'd77, 1); step(0, 0, 8'd66, 1);
      step(0, 1, 8'd8, 1);  step(0, 1, 8'd12, 1); step(0, 0, 8'd55, 1);
      chk("gap_not_early", int'(bus.out_valid), 0);
      step(0, 1, 8'd16, 1);
      chk("gap_value", int'(bus.out_data), 10);
      idle(1);

      // Overflow: 5 results into a depth-4 FIFO with no consumer
      for (int i = 0; i < 20; i++) step(0, 1, 8'd8, 0);
      chk("ovf_level", int'(bus.level), 4);
      chk("ovf_valid", int'(bus.out_valid), 1);
      chk("ovf_flag", int'(bus.overflow), 1);
      chk("ovf_data", int'(bus.out_data), 8);
      step(0, 0, 8'd0, 0);
      chk("ovf_hold_data", int'(bus.out_data), 8);
      for (int i = 0; i < 4; i++) begin
         chk("drain_data", int'(bus.out_data), 8);
         step(0, 0, 8'd0, 1);
      end
      chk("drain_empty", int'(bus.out_valid), 0);
      chk("ovf_sticky", int'(bus.overflow), 1);

      // Full FIFO with simultaneous push and pop
      step(1, 0, 8'd0, 0);
      for (int v = 1; v <= 4; v++)
         for (int i = 0; i < 4; i++) step(0, 1, 8'(v), 0);
      chk("full_level", int'(bus.level), 4);
      for (int i = 0; i < 3; i++) step(0, 1, 8'd5, 0);
      step(0, 1, 8'd5, 1);
      chk("pp_level", int'(bus.level), 4);
      chk("pp_overflow", int'(bus.overflow), 0);
      for (int v = 2; v <= 5; v++) begin
         chk("pp_order", int'(bus.out_data), v);
         step(0, 0, 8'd0, 1);
      end
      chk("pp_empty", int'(bus.out_valid), 0);

      // Reset discards a partial window
      step(0, 1, 8'd100, 1);
      step(0, 1, 8'd100, 1);
      step(1, 1, 8'd100, 1);
      chk("prst_empty", int'(bus.out_valid), 0);
      for (int i = 0; i < 4; i++) step(0, 1, 8'd4, 0);
      chk("prst_value", int'(bus.out_data), 4);
      chk("prst_level", int'(bus.level), 1);
      chk("prst_overflow", int'(bus.overflow), 0);

      // Randomized traffic: slow consumer first (fills/overflows), then fast
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 399) == 0),
              ($urandom_range(0, 3) != 0),
              8'($urandom),
              (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
